mdio_master_ctrl: RTL and testbench
===================================

Name: mdio_master_ctrl

Overview:
- Synthesizable IEEE 802.3 Clause 22 MDIO station-management master.
- Generates MDC from the system clock and serializes read/write management frames onto mdo/mdo_en.
- Samples mdi during read turnaround and data phases.
- Faces the MMD/PHY-side MDIO slave and its mdc/mdi/mdo/mdo_en signal set. The host side is a valid/ready command port with a one-cycle response pulse.

Parameters:
- CLK_DIV, 10: clk cycles per mdc period; even, >= 4. mdc high and low phases are each CLK_DIV/2 clk cycles.
- PRE_LEN, 32: preamble length in mdc cycles (all ones), 1..32.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  controller idle, command accepted when cmd_valid&cmd_ready
- cmd_write  input  1  1=write (OP=01), 0=read (OP=10)
- cmd_phy_addr  input  5  PHYAD
- cmd_reg_addr  input  5  REGAD
- cmd_wdata  input  16  write data
- rsp_valid  output  1  one-clk pulse, frame complete
- rsp_rdata  output  16  read data, held until next rsp_valid
- rsp_ta_err  output  1  read only: mdi was 1 in TA bit 2 (no responder)
- mdc  output  1  management clock
- mdo  output  1  serial data to slave
- mdo_en  output  1  mdo drive enable; 0 = released
- mdi  input  1  serial data from slave

Behaviour:
- Single clock domain is clk. Reset is asynchronous and active-low via rst_n.
- Reset values: mdc=0, mdo=1, mdo_en=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_ta_err=0, state=IDLE, divider=0. cmd_ready rises on the first clk after rst_n deasserts.
- mdc is free-running from reset release. The divider counts 0..CLK_DIV-1; mdc=1 for counts >= CLK_DIV/2.
- "Fall tick": the clk on which mdc goes 1->0. "Rise tick": the clk on which mdc goes 0->1.
- mdo/mdo_en update only on fall ticks. mdi is sampled on the rise tick, using the value present on that clk edge.
- Command capture:
  - On cmd_valid&cmd_ready, all cmd_* fields are registered and cmd_ready drops the next clk.
  - Fields changing afterwards have no effect.
- States (bit counter counts mdc cycles, each transition on a fall tick):
  - IDLE: mdo_en=0, mdo=1. A captured command moves to PRE at the next fall tick.
  - PRE: mdo_en=1, mdo=1 for PRE_LEN bits.
  - HDR: 14 bits, MSB first: ST=01, OP, PHYAD[4:0], REGAD[4:0].
  - TA, write: drive 1 then 0.
  - TA, read: mdo_en=0 for both bits. The second-bit rise-tick sample sets rsp_ta_err if mdi=1.
  - DATA, write: drive cmd_wdata[15:0] MSB first.
  - DATA, read: mdo_en=0; shift mdi on 16 rise ticks, MSB first.
  - DONE: mdo_en=0, mdo=1. Pulse rsp_valid for 1 clk on that fall tick. Update rsp_rdata (reads only; writes leave it unchanged) and rsp_ta_err (0 for writes). Return to IDLE; cmd_ready=1 the next clk.
- Frame length is PRE_LEN+32 mdc cycles. Default frame is 64 mdc cycles.
- Latency: command accept to rsp_valid is ≤ (PRE_LEN+33)*CLK_DIV clk cycles.
- Back-to-back commands: a new command is accepted only after rsp_valid. At least one full idle mdc cycle with mdo_en=0 separates frames.
- cmd_valid while busy: ignored, no queuing.
- rst_n asserted mid-frame: immediate abort, all outputs to reset values, no rsp_valid for the aborted frame.
- Read with no responder (mdi pulled high): rsp_ta_err=1, rsp_rdata=16'hFFFF.

Optional Feature:
- MDIO_M_PREAMBLE_SUPPRESS_EN defined: adds input port cmd_no_pre (1 bit), captured with the command.
  - If cmd_no_pre=1, PRE is skipped and IDLE goes directly to HDR. The frame is 32 mdc cycles.
  - If cmd_no_pre=0, behaviour is unchanged.
- Macro undefined: no cmd_no_pre port; the preamble is always sent.

Test Plan:
- Write PHY=5'h01 REG=5'h00 DATA=16'h1140, CLK_DIV=10:
  - mdo bit stream on rise ticks = 32x'1', 01 01 00001 00000 10, then 0001000101000000.
  - mdo_en=1 for 64 mdc cycles; rsp_valid once; rsp_ta_err=0.
- Read PHY=5'h03 REG=5'h02, slave responds with TA bit2=0 and data 16'h0141:
  - mdo_en=0 from the TA first bit through data end.
  - rsp_rdata=16'h0141, rsp_ta_err=0.
- Read with mdi tied 1 -> rsp_ta_err=1, rsp_rdata=16'hFFFF.
- cmd_valid held high, alternating write/read, 3 commands -> 3 rsp_valid pulses, ≥1 idle mdc cycle between frames. A cmd_valid pulse mid-frame is not accepted.
- rst_n low at mdc cycle 40 of a write -> mdo_en=0, mdc=0 within the same clk. No rsp_valid. cmd_ready=1 one clk after release. A subsequent read completes correctly.
- With MDIO_M_PREAMBLE_SUPPRESS_EN, cmd_no_pre=1 read -> frame is 32 mdc cycles, first mdo bits are 0,1 (ST), correct rsp_rdata.

Source files
------------

// File: rtl/mdio_master_ctrl.sv
// IEEE 802.3 Clause 22 MDIO management master: MDC divider plus frame serializer.
// Optional build macro MDIO_M_PREAMBLE_SUPPRESS_EN adds the cmd_no_pre input.
module mdio_master_ctrl #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_pre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_en,
  input  logic        mdi
);

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [DivW-1:0] DivRise = DivW'(CLK_DIV / 2 - 1);
  localparam logic [4:0]      PreLast = 5'(PRE_LEN - 1);

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      bit_q, bit_d;
  logic            pend_q, pend_d, ready_q, ready_d;
  logic            wr_q, wr_d, no_pre_q, no_pre_d;
  logic [13:0]     hdr_q, hdr_d;
  logic [15:0]     wdata_q, wdata_d, shift_q, shift_d;
  logic            ta_q, ta_d;
  logic            mdo_q, mdo_d, mdo_en_q, mdo_en_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_ta_err_q, rsp_ta_err_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            no_pre_in, accept, fall, rise;

`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
  assign no_pre_in = cmd_no_pre;
`else
  assign no_pre_in = 1'b0;
`endif

  assign accept = cmd_valid & ready_q;
  assign fall   = (div_q == DivLast);
  assign rise   = (div_q == DivRise);

  always_comb begin
    state_d      = state_q;
    div_d        = fall ? '0 : div_q + 1'b1;
    bit_d        = bit_q;
    pend_d       = pend_q;
    ready_d      = (state_q == StIdle) && !pend_q && !accept;
    wr_d         = wr_q;
    no_pre_d     = no_pre_q;
    hdr_d        = hdr_q;
    wdata_d      = wdata_q;
    shift_d      = shift_q;
    ta_d         = ta_q;
    mdo_d        = mdo_q;
    mdo_en_d     = mdo_en_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_ta_err_d = rsp_ta_err_q;

    if (accept) begin
      pend_d   = 1'b1;
      wr_d     = cmd_write;
      no_pre_d = no_pre_in;
      hdr_d    = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr};
      wdata_d  = cmd_wdata;
    end

    // mdi is only meaningful while the slave owns the line
    if (rise) begin
      if (state_q == StTa && bit_q == 5'd1) ta_d = mdi;
      if (state_q == StData) shift_d = {shift_q[14:0], mdi};
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = no_pre_q ? StHdr : StPre;
            bit_d   = '0;
          end
        end
        StPre: begin
          if (bit_q == PreLast) begin
            state_d = StHdr;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        StHdr: begin
          if (bit_q == 5'd13) begin
            state_d = StTa;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        StTa: begin
          if (bit_q == 5'd1) begin
            state_d = StData;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        StData: begin
          if (bit_q == 5'd15) begin
            state_d      = StIdle;
            bit_d        = '0;
            rsp_valid_d  = 1'b1;
            rsp_ta_err_d = wr_q ? 1'b0 : ta_q;
            if (!wr_q) rsp_rdata_d = shift_q;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      // Line value for the bit that starts on this fall tick
      unique case (state_d)
        StPre:   begin mdo_en_d = 1'b1; mdo_d = 1'b1; end
        StHdr:   begin mdo_en_d = 1'b1; mdo_d = hdr_q[4'd13 - bit_d[3:0]]; end
        StTa:    begin mdo_en_d = wr_q; mdo_d = wr_q ? ~bit_d[0] : 1'b1; end
        StData:  begin mdo_en_d = wr_q; mdo_d = wr_q ? wdata_q[4'd15 - bit_d[3:0]] : 1'b1; end
        default: begin mdo_en_d = 1'b0; mdo_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      pend_q       <= 1'b0;
      ready_q      <= 1'b0;
      wr_q         <= 1'b0;
      no_pre_q     <= 1'b0;
      hdr_q        <= '0;
      wdata_q      <= '0;
      shift_q      <= '0;
      ta_q         <= 1'b0;
      mdo_q        <= 1'b1;
      mdo_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_ta_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      pend_q       <= pend_d;
      ready_q      <= ready_d;
      wr_q         <= wr_d;
      no_pre_q     <= no_pre_d;
      hdr_q        <= hdr_d;
      wdata_q      <= wdata_d;
      shift_q      <= shift_d;
      ta_q         <= ta_d;
      mdo_q        <= mdo_d;
      mdo_en_q     <= mdo_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_ta_err_q <= rsp_ta_err_d;
    end
  end

  assign mdc        = (div_q >= DivHalf);
  assign mdo        = mdo_q;
  assign mdo_en     = mdo_en_q;
  assign cmd_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_ta_err = rsp_ta_err_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Scoreboard bench for mdio_master_ctrl: random commands, a PHY responder model and
// frame-level expected bit streams; honours MDIO_M_PREAMBLE_SUPPRESS_EN when defined.
module tb_mdio_master_ctrl;
  localparam int unsigned CD = 10;
  localparam int unsigned PL = 32;
  localparam int LatMax = (PL + 33) * CD;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_ta_err, mdc, mdo, mdo_en;
  logic [15:0] rsp_rdata;
  logic        mdi = 1'b1;
`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
  logic        cmd_no_pre = 1'b0;
`endif

  mdio_master_ctrl #(.CLK_DIV(CD), .PRE_LEN(PL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_phy_addr (cmd_phy_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre   (cmd_no_pre),
`endif
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_ta_err   (rsp_ta_err),
    .mdc          (mdc),
    .mdo          (mdo),
    .mdo_en       (mdo_en),
    .mdi          (mdi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] rdata;
    logic        ta;
    logic [63:0] bits;
    logic [63:0] en;
    int          n;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, passed = 0;
  int          cyc = 0, n_hs = 0, n_issued = 0;
  logic [15:0] mem [0:1023];
  logic [15:0] last_rdata = '0;
  // Current frame as seen by the PHY model
  logic        cur_w = 1'b1, cur_present = 1'b0;
  logic [15:0] cur_rd = '0;
  int          cur_p = 0, cur_n = 64;
  // Bus monitor state
  bit          in_frame = 1'b0;
  logic        prev_en = 1'b0;
  int          k = 0;
  logic [63:0] got_b = '0, got_e = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  function automatic logic bitof16(input logic [15:0] v, input int i);
    logic [15:0] t;
    t = v >> i;
    return t[0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) n_hs++;

  // Collect one mdo/mdo_en sample per mdc rising edge while a frame is on the wire
  always begin
    @(posedge mdc or negedge rst_n);
    if (!rst_n) begin
      in_frame = 1'b0;
      prev_en  = 1'b0;
    end else begin
      #1;
      if (!in_frame && mdo_en) begin
        chk("idle_gap", {63'd0, prev_en}, 64'd0);
        in_frame = 1'b1;
        k        = 0;
        got_b    = '0;
        got_e    = '0;
      end
      if (in_frame) begin
        got_e = got_e | (64'(mdo_en) << k);
        got_b = got_b | (64'(mdo) << k);
        k++;
        if (k >= cur_n) in_frame = 1'b0;
      end
      prev_en = mdo_en;
    end
  end

  // PHY responder: drives mdi after each mdc fall for the bit now in progress
  always begin
    logic [15:0] t;
    int          j;
    @(negedge mdc);
    #1;
    mdi = 1'b1;
    if (in_frame && !cur_w) begin
      if (k == cur_p + 15) begin
        mdi = !cur_present;
      end else if (k >= cur_p + 16 && k < cur_p + 32) begin
        j   = k - cur_p - 16;
        t   = cur_rd << j;
        mdi = t[15];
      end
    end
  end

  // Response monitor
  always begin
    exp_t        e;
    logic [63:0] mask;
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      sb.delete();
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e    = sb.pop_front();
        mask = (e.n >= 64) ? '1 : ((64'd1 << e.n) - 64'd1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_ta_err", 64'(rsp_ta_err), 64'(e.ta));
        chk("mdo_en_stream", got_e & mask, e.en & mask);
        chk("mdo_stream", got_b & e.en, e.bits & e.en);
        chk("latency", 64'((cyc - e.acc) <= LatMax), 64'd1);
      end
    end
  end

  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] d, input logic np, input bit hold);
    exp_t        e;
    int          t, p;
    logic        npe, present, bv, ev;
    logic [13:0] hdr;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_write    = w;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata    = d;
`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
    cmd_no_pre   = np;
    npe          = np;
`else
    npe          = 1'b0;
`endif
    t = 0;
    while (!cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    n_issued++;
    // Reference: PHYs 0..23 respond, the rest leave the line pulled high
    present = (pa < 5'd24);
    p       = npe ? 0 : int'(PL);
    hdr     = {2'b01, w ? 2'b01 : 2'b10, pa, ra};
    e.wr    = w;
    e.acc   = cyc;
    e.n     = p + 32;
    if (w) begin
      if (present) mem[{pa, ra}] = d;
      e.rdata = last_rdata;
      e.ta    = 1'b0;
    end else begin
      e.rdata    = present ? mem[{pa, ra}] : 16'hFFFF;
      e.ta       = !present;
      last_rdata = e.rdata;
    end
    e.bits = '0;
    e.en   = '0;
    for (int i = 0; i < e.n; i++) begin
      if (i < p) begin
        bv = 1'b1; ev = 1'b1;
      end else if (i < p + 14) begin
        bv = bitof16(16'(hdr), p + 13 - i); ev = 1'b1;
      end else if (i < p + 16) begin
        ev = w; bv = w ? (i == p + 14) : 1'b1;
      end else begin
        ev = w; bv = w ? bitof16(d, p + 31 - i) : 1'b1;
      end
      e.bits = e.bits | (64'(bv) << i);
      e.en   = e.en | (64'(ev) << i);
    end
    cur_w       = w;
    cur_present = present;
    cur_rd      = e.rdata;
    cur_p       = p;
    cur_n       = e.n;
    sb.push_back(e);
    if (!hold) cmd_valid = 1'b0;
    // Scramble fields after capture; the frame must not follow them
    cmd_write    = 1'($urandom);
    cmd_phy_addr = 5'($urandom);
    cmd_reg_addr = 5'($urandom);
    cmd_wdata    = 16'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[{5'h03, 5'h02}] = 16'h0141;

    repeat (3) @(negedge clk);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdo", 64'(mdo), 64'd1);
    chk("rst_mdo_en", 64'(mdo_en), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_ta_err", 64'(rsp_ta_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    issue(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0);
    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b0);
    issue(1'b0, 5'h1F, 5'h05, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++)
      issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom));

    // cmd_valid held across three alternating commands
    issue(1'b1, 5'h02, 5'h04, 16'hA5C3, 1'b0, 1'b1);
    issue(1'b0, 5'h02, 5'h04, 16'h0000, 1'b0, 1'b1);
    issue(1'b1, 5'h1E, 5'h07, 16'h5A5A, 1'b0, 1'b0);

    // A pulse while busy must be ignored
    issue(1'b1, 5'h04, 5'h09, 16'h1234, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    chk("busy_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // Abort a write in mid-frame
    issue(1'b1, 5'h06, 5'h01, 16'hBEEF, 1'b0, 1'b0);
    t = 0;
    while (!(in_frame && k >= 40) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached", 64'(in_frame && k >= 40), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mdo_en", 64'(mdo_en), 64'd0);
    chk("abort_mdc", 64'(mdc), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    last_rdata = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_rdata", 64'(rsp_rdata), 64'd0);
    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, 1'b0);

`ifdef MDIO_M_PREAMBLE_SUPPRESS_EN
    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b0);
    issue(1'b1, 5'h05, 5'h0A, 16'hC001, 1'b1, 1'b0);
    issue(1'b0, 5'h05, 5'h0A, 16'h0000, 1'b1, 1'b0);
`endif

    drain();
    chk("handshakes", 64'(n_hs), 64'(n_issued));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
